// File: rtl/dpram_param.sv
// rtl/dpram_param.sv - simple dual-port RAM with a clear engine, read-valid strobe and sticky error flags
// Optional macro WR_BYPASS_EN: a same-address read during a write returns the new data.
module dpram_param #(
  parameter int                 DATA_W  = 8,
  parameter int                 ADDR_W  = 4,
  parameter int                 DEPTH   = 16,
  parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              re,
  input  logic              clr,
  output logic [DATA_W-1:0] data_out,
  output logic              rvalid,
  output logic              init_busy,
  output logic              acc_err,
  output logic              addr_err
);

  typedef enum logic {INIT, READY} state_t;

  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rvalid_q, rvalid_d;
  logic              acc_err_q, acc_err_d;
  logic              addr_err_q, addr_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;
  logic              waddr_ok, raddr_ok;

  assign waddr_ok = {1'b0, waddr} < DEPTH_X;
  assign raddr_ok = {1'b0, raddr} < DEPTH_X;

`ifdef WR_BYPASS_EN
  assign rd_word = (we && (waddr == raddr)) ? data_in : mem[raddr];
`else
  assign rd_word = mem[raddr];
`endif

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    data_out_d = data_out_q;
    rvalid_d   = 1'b0;
    acc_err_d  = acc_err_q;
    addr_err_d = addr_err_q;
    mem_we     = 1'b0;
    mem_waddr  = waddr;
    mem_wdata  = data_in;
    case (state_q)
      INIT: begin
        // The clear engine owns the write port; user accesses are only flagged.
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = CLR_VAL;
        if (clr_ptr_q == LAST) begin
          state_d   = READY;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
        if (we || re) acc_err_d = 1'b1;
      end
      READY: begin
        if (clr) begin
          state_d   = INIT;
          clr_ptr_d = '0;
          if (we || re) acc_err_d = 1'b1;
        end else begin
          if (we) begin
            if (waddr_ok) mem_we = 1'b1;
            else          addr_err_d = 1'b1;
          end
          if (re) begin
            rvalid_d = 1'b1;
            if (raddr_ok) begin
              data_out_d = rd_word;
            end else begin
              data_out_d = '0;
              addr_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= INIT;
      clr_ptr_q  <= '0;
      data_out_q <= '0;
      rvalid_q   <= 1'b0;
      acc_err_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      data_out_q <= data_out_d;
      rvalid_q   <= rvalid_d;
      acc_err_q  <= acc_err_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Array has no reset; contents are defined by the clear engine.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign data_out  = data_out_q;
  assign rvalid    = rvalid_q;
  assign init_busy = (state_q == INIT);
  assign acc_err   = acc_err_q;
  assign addr_err  = addr_err_q;

endmodule

// File: tb/tb_dpram_param.sv
// tb/tb_dpram_param.sv - directed self-checking bench for dpram_param (DEPTH=16 and DEPTH=12 instances)
module tb_dpram_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = '0;
  logic [3:0] waddr = '0;
  logic       we = 1'b0;
  logic [3:0] raddr = '0;
  logic       re = 1'b0;
  logic       clr = 1'b0;

  logic [7:0] d16_dout, d12_dout;
  logic       d16_rv, d16_busy, d16_acc, d16_addr;
  logic       d12_rv, d12_busy, d12_acc, d12_addr;

  int n_cmp = 0;
  int n_mis = 0;
  int n;
  logic [7:0] coll_exp;

  dpram_param u_dut16 (
    .clk(clk), .reset(reset), .data_in(data_in), .waddr(waddr), .we(we),
    .raddr(raddr), .re(re), .clr(clr), .data_out(d16_dout), .rvalid(d16_rv),
    .init_busy(d16_busy), .acc_err(d16_acc), .addr_err(d16_addr)
  );

  dpram_param #(.DEPTH(12)) u_dut12 (
    .clk(clk), .reset(reset), .data_in(data_in), .waddr(waddr), .we(we),
    .raddr(raddr), .re(re), .clr(clr), .data_out(d12_dout), .rvalid(d12_rv),
    .init_busy(d12_busy), .acc_err(d12_acc), .addr_err(d12_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cnt);
    cnt = 0;
    while (d16_busy && cnt < 40) begin
      tick();
      cnt++;
    end
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    int c;
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    wait_init(c);
    chk(tag, c, 16);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    we = 1'b1; waddr = a; data_in = d; re = 1'b0;
    tick();
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    re = 1'b1; raddr = a; we = 1'b0;
    tick();
    re = 1'b0;
  endtask

  initial begin
    // 1. reset and post-reset init with a read held pending
    re = 1'b1; raddr = 4'd3;
    #3 reset = 1'b0;
    tick(); tick();
    chk("rst_dout", d16_dout, 0);
    chk("rst_rvalid", d16_rv, 0);
    chk("rst_busy", d16_busy, 1);
    chk("rst_acc", d16_acc, 0);
    chk("rst_addr", d16_addr, 0);
    reset = 1'b1;
    n = 0;
    while (d16_busy && n < 40) begin
      tick();
      n++;
      if (d16_rv) chk("init_rvalid", d16_rv, 0);
    end
    chk("init_len", n, 16);
    chk("init_acc", d16_acc, 1);
    tick();
    chk("first_rd_data", d16_dout, 8'h00);
    chk("first_rd_rv", d16_rv, 1);
    idle();

    // 2. write then read, then hold
    wr(4'd5, 8'hA5);
    rd(4'd5);
    chk("wr_rd_data", d16_dout, 8'hA5);
    chk("wr_rd_rv", d16_rv, 1);
    tick();
    chk("hold_rv", d16_rv, 0);
    chk("hold_data", d16_dout, 8'hA5);

    // 3. same-address collision and independent different-address access
    wr(4'd7, 8'h11);
    we = 1'b1; waddr = 4'd7; data_in = 8'h22; re = 1'b1; raddr = 4'd7;
    tick();
`ifdef WR_BYPASS_EN
    coll_exp = 8'h22;
`else
    coll_exp = 8'h11;
`endif
    chk("coll_data", d16_dout, coll_exp);
    chk("coll_rv", d16_rv, 1);
    idle();
    rd(4'd7);
    chk("coll_after", d16_dout, 8'h22);
    we = 1'b1; waddr = 4'd9; data_in = 8'h33; re = 1'b1; raddr = 4'd5;
    tick();
    idle();
    chk("diff_rd", d16_dout, 8'hA5);
    rd(4'd9);
    chk("diff_wr", d16_dout, 8'h33);

    // 4. soft clear with a write dropped in the clr cycle
    do_reset("rst4_len");
    for (int i = 0; i < 16; i++) wr(4'(i), 8'hFF);
    rd(4'd15);
    chk("fill_rd", d16_dout, 8'hFF);
    chk("pre_clr_acc", d16_acc, 0);
    clr = 1'b1; we = 1'b1; waddr = 4'd2; data_in = 8'h77;
    tick();
    idle();
    chk("clr_busy", d16_busy, 1);
    chk("clr_rvalid", d16_rv, 0);
    chk("clr_acc", d16_acc, 1);
    wait_init(n);
    chk("clr_len", n + 1, 16 + 1);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      chk($sformatf("clr_rd%0d", i), d16_dout, 8'h00);
    end

    // 5. out-of-range access on the DEPTH=12 instance
    do_reset("rst5_len");
    chk("d12_ready", d12_busy, 0);
    wr(4'd11, 8'h77);
    wr(4'd0, 8'h44);
    chk("d12_addr_pre", d12_addr, 0);
    wr(4'd13, 8'h5A);
    chk("d12_addr_wr", d12_addr, 1);
    chk("d16_addr_wr", d16_addr, 0);
    rd(4'd13);
    chk("oor_data", d12_dout, 8'h00);
    chk("oor_rv", d12_rv, 1);
    chk("d16_rd13", d16_dout, 8'h5A);
    rd(4'd1);
    chk("alias_w1", d12_dout, 8'h00);
    rd(4'd11);
    chk("keep_w11", d12_dout, 8'h77);
    rd(4'd0);
    chk("keep_w0", d12_dout, 8'h44);

    // 6. reset mid-operation, then mid-init
    reset = 1'b0;
    #1;
    chk("mid_op_dout", d16_dout, 0);
    chk("mid_op_busy", d16_busy, 1);
    chk("mid_op_addr12", d12_addr, 0);
    reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("mid_init_busy", d16_busy, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_init_dout", d16_dout, 0);
    chk("mid_init_rv", d16_rv, 0);
    chk("mid_init_acc", d16_acc, 0);
    tick();
    reset = 1'b1;
    wait_init(n);
    chk("restart_len", n, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/dpram_param.md
Name: dpram_param

Overview:
Parametrised simple dual-port RAM: one write port and one read port on a single clock. It is the successor to the fixed 16x8 DPRAM and adds these features:
- configurable width, depth and clear value
- sequential memory-clear engine run after reset and on demand
- read-valid strobe
- out-of-range address detection
- sticky error flags

It is used as generic scratch or buffer storage behind UVM-verified datapath blocks.

Parameters:
DATA_W, 8, data width in bits
ADDR_W, 4, address width in bits
DEPTH, 16, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W
CLR_VAL, 0, DATA_W-bit value written to every word by the clear engine

Ports:
clk  input  1  clock; all logic on posedge
reset  input  1  asynchronous, active-low reset
data_in  input  DATA_W  write data
waddr  input  ADDR_W  write address
we  input  1  write enable
raddr  input  ADDR_W  read address
re  input  1  read enable
clr  input  1  soft clear request, single-cycle pulse
data_out  output  DATA_W  registered read data
rvalid  output  1  data_out updated this cycle
init_busy  output  1  clear engine running; ports ignored
acc_err  output  1  sticky: access attempted while busy, or dropped by clr
addr_err  output  1  sticky: waddr or raddr >= DEPTH on an enabled access

Behaviour:
- Reset (reset=0, asynchronous), output values:
  - state=INIT, clr_ptr=0
  - data_out=0, rvalid=0, init_busy=1, acc_err=0, addr_err=0
  - memory array is not reset directly; the clear engine clears it
- FSM states: INIT and READY.
- INIT:
  - each posedge writes mem[clr_ptr]<=CLR_VAL, then clr_ptr increments.
  - on the edge that writes word DEPTH-1, the FSM moves to READY and init_busy goes 0.
  - init_busy is therefore high for exactly DEPTH rising edges after reset deasserts.
- INIT, port handling:
  - we, re and clr are ignored; rvalid stays 0 and data_out holds.
  - any we=1 or re=1 sets acc_err.
- READY:
  - we=1 with waddr<DEPTH: mem[waddr]<=data_in.
  - re=1 with raddr<DEPTH: data_out<=mem[raddr] and rvalid=1 on the next edge. Read latency is 1 cycle.
  - re=0: rvalid=0 and data_out holds its last value.
- Out of range, in READY:
  - we with waddr>=DEPTH: write dropped, addr_err set.
  - re with raddr>=DEPTH: data_out<=0, rvalid=1, addr_err set.
- clr=1 in READY:
  - next state INIT, clr_ptr<=0, init_busy<=1.
  - a we or re in the same cycle is dropped and sets acc_err; rvalid=0.
- Simultaneous we and re to the same address in READY: result is set by WR_BYPASS_EN (see below).
- Simultaneous we and re to different addresses: both complete independently.
- Reset asserted mid-INIT or mid-operation: immediate return to reset values; the clear restarts from word 0 after release.
- Error flags are sticky and are cleared only by reset, not by clr.
- clr_ptr is ADDR_W bits wide. It never wraps past DEPTH-1; the transition to READY occurs first.

Optional Feature:
WR_BYPASS_EN
- Defined: same-address read during write returns the new value. data_out<=data_in and rvalid=1.
- Undefined: same-address read during write returns the old value. data_out<=previous mem[raddr] and rvalid=1.
- The write commits in both cases.

Test Plan:
All scenarios use defaults DATA_W=8, ADDR_W=4, DEPTH=16, CLR_VAL=0 unless stated.
1. Post-reset init:
   - release reset, hold re=1 raddr=3 throughout.
   - init_busy=1 for 16 edges, rvalid=0, acc_err=1.
   - after READY, next edge gives data_out=8'h00, rvalid=1.
2. Write then read:
   - we waddr=5 data_in=8'hA5, next cycle re raddr=5.
   - one cycle later data_out=8'hA5, rvalid=1.
   - following cycle with re=0: rvalid=0, data_out holds 8'hA5.
3. Same-address collision:
   - mem[7]=8'h11, then we waddr=7 data_in=8'h22 with re raddr=7 in the same cycle.
   - data_out=8'h11 without WR_BYPASS_EN, 8'h22 with it.
   - next read of 7 returns 8'h22 in both builds.
4. Soft clear:
   - fill all 16 words with 8'hFF, pulse clr with we waddr=2 in the same cycle.
   - init_busy=1 for 16 edges, acc_err=1.
   - then every read returns 8'h00.
5. Out-of-range (DEPTH=12):
   - we waddr=13 data_in=8'h5A, then re raddr=13.
   - data_out=8'h00, rvalid=1, addr_err=1; no in-range word modified.
6. Reset mid-init:
   - assert reset at the 8th INIT edge, release.
   - outputs return to reset values immediately.
   - init_busy then stays high for a full 16 edges.
